// File: rtl/triwave_seq_pkg.sv
// Shared definitions for the triangle-wave PWM sequencer.
//   state_t   : sequencer FSM states
//   DEF_*     : default widths and channel count
//   ch_idx_w  : channel index width, never less than one bit
// Optional build macro used elsewhere: TRIWAVE_SEQ_GAMMA_EN.
package triwave_seq_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 6;
  localparam int DEF_HOLD_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    HOLD_HI,
    RAMP_DOWN,
    HOLD_LO
  } state_t;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/triwave_seq_if.sv
// Signal bundle between the board switches, the sequencer and the PWM pins.
//   enable_sw    : per-channel enable switches
//   step         : duty increment/decrement per PWM period (0 acts as 1)
//   hold_periods : PWM periods spent in each hold state
//   pulse        : registered PWM outputs
//   duty_cycle   : effective duty of the active channel
//   active_ch    : granted channel
//   busy         : sequencer is not idle
//   cycle_done   : one-clock pulse at the end of a full channel cycle
// Modports: master = switch/pin side, slave = sequencer.
interface triwave_seq_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 6,
  parameter int HOLD_W = 4
);
  localparam int CH_W = triwave_seq_pkg::ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] enable_sw;
  logic [CNT_W-1:0]  step;
  logic [HOLD_W-1:0] hold_periods;
  logic [NUM_CH-1:0] pulse;
  logic [CNT_W-1:0]  duty_cycle;
  logic [CH_W-1:0]   active_ch;
  logic              busy;
  logic              cycle_done;

  modport master (
    output enable_sw, step, hold_periods,
    input  pulse, duty_cycle, active_ch, busy, cycle_done
  );

  modport slave (
    input  enable_sw, step, hold_periods,
    output pulse, duty_cycle, active_ch, busy, cycle_done
  );
endinterface

// File: rtl/triwave_rr_pick.sv
// Combinational round-robin picker: finds the first set request bit after
// ptr, wrapping, with ptr itself checked last.
//   req     : request vector
//   ptr     : last granted index
//   grant   : chosen index (ptr when nothing is requested)
//   any_req : at least one request bit is set
module triwave_rr_pick
  import triwave_seq_pkg::*;
#(
  parameter int  NUM_CH = DEF_NUM_CH,
  localparam int CH_W   = ch_idx_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   grant,
  output logic              any_req
);

  int idx;

  // Scan from the farthest candidate to the nearest so the last hit wins,
  // leaving the nearest set bit after ptr as the grant.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    grant   = ptr;
    any_req = |req;
    idx     = 0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (req[CH_W'(idx)]) grant = CH_W'(idx);
    end
  end

endmodule

// File: rtl/triwave_seq_ctrl.sv
// Triangle-wave ("breathing") PWM sequencer. One free-running PWM counter and
// one duty ramp engine are shared round-robin between NUM_CH channels; each
// grant runs ramp-up / hold / ramp-down / hold once. Duty, state, hold count
// and grant change only at the end of a PWM period.
//   sysclk : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : triwave_seq_if slave (switches in, PWM/status out)
// Build option: define TRIWAVE_SEQ_GAMMA_EN to square the duty ((d*d)>>CNT_W)
// for a perceptual brightness curve; otherwise the duty is linear.
module triwave_seq_ctrl
  import triwave_seq_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int HOLD_W = DEF_HOLD_W
) (
  input logic          sysclk,
  input logic          rst_n,
  triwave_seq_if.slave bus
);

  localparam int               CH_W = ch_idx_w(NUM_CH);
  localparam logic [CNT_W-1:0] MAX  = '1;

  state_t            state, state_n;
  logic [CNT_W-1:0]  count, duty, duty_n, duty_eff, step_r, step_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n, hold_r, hold_n;
  logic [CH_W-1:0]   ptr, ptr_n, active, active_n, grant;
  logic [NUM_CH-1:0] pulse_r, pulse_n;
  logic              done_r, done_n, any_req, period_end, busy, arb;
  logic [CNT_W:0]    up_sum;

  assign period_end = (count == MAX);
  assign busy       = (state != IDLE);
  // One extra bit so duty + step cannot wrap before the MAX comparison.
  assign up_sum     = {1'b0, duty} + {1'b0, step_r};

`ifdef TRIWAVE_SEQ_GAMMA_EN
  assign duty_eff = CNT_W'(({{CNT_W{1'b0}}, duty} * {{CNT_W{1'b0}}, duty}) >> CNT_W);
`else
  assign duty_eff = duty;
`endif

  triwave_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req     (bus.enable_sw),
    .ptr     (ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  always_comb begin
    state_n    = state;
    duty_n     = duty;
    hold_cnt_n = hold_cnt;
    ptr_n      = ptr;
    active_n   = active;
    step_n     = step_r;
    hold_n     = hold_r;
    done_n     = 1'b0;
    arb        = 1'b0;
    if (period_end) begin
      // Losing the active enable aborts the cycle; ptr is kept for fairness.
      if (busy && !bus.enable_sw[active]) begin
        state_n = IDLE;
        duty_n  = '0;
      end else begin
        case (state)
          IDLE: arb = 1'b1;
          RAMP_UP: begin
            if (up_sum >= {1'b0, MAX}) begin
              duty_n     = MAX;
              hold_cnt_n = '0;
              state_n    = HOLD_HI;
            end else begin
              duty_n = up_sum[CNT_W-1:0];
            end
          end
          HOLD_HI: begin
            if (hold_cnt == hold_r) state_n = RAMP_DOWN;
            else hold_cnt_n = hold_cnt + 1'b1;
          end
          RAMP_DOWN: begin
            if (duty <= step_r) begin
              duty_n     = '0;
              hold_cnt_n = '0;
              state_n    = HOLD_LO;
            end else begin
              duty_n = duty - step_r;
            end
          end
          HOLD_LO: begin
            if (hold_cnt == hold_r) begin
              done_n = 1'b1;
              arb    = 1'b1;
            end else begin
              hold_cnt_n = hold_cnt + 1'b1;
            end
          end
          default: state_n = IDLE;
        endcase
      end
      // Grant point shared by IDLE and a completed HOLD_LO (back-to-back).
      if (arb) begin
        duty_n = '0;
        if (any_req) begin
          active_n = grant;
          ptr_n    = grant;
          step_n   = (bus.step == '0) ? CNT_W'(1) : bus.step;
          hold_n   = bus.hold_periods;
          state_n  = RAMP_UP;
        end else begin
          state_n = IDLE;
        end
      end
    end
  end

  always_comb begin
    pulse_n = '0;
    if (busy && bus.enable_sw[active] && (count < duty_eff)) pulse_n[active] = 1'b1;
  end

  always_ff @(posedge sysclk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      count    <= '0;
      state    <= IDLE;
      duty     <= '0;
      hold_cnt <= '0;
      step_r   <= CNT_W'(1);
      hold_r   <= '0;
      ptr      <= CH_W'(NUM_CH - 1);
      active   <= '0;
      pulse_r  <= '0;
      done_r   <= 1'b0;
    end else begin
      count    <= count + 1'b1;
      state    <= state_n;
      duty     <= duty_n;
      hold_cnt <= hold_cnt_n;
      step_r   <= step_n;
      hold_r   <= hold_n;
      ptr      <= ptr_n;
      active   <= active_n;
      pulse_r  <= pulse_n;
      done_r   <= done_n;
    end
  end

  assign bus.pulse      = pulse_r;
  assign bus.duty_cycle = duty_eff;
  assign bus.active_ch  = active;
  assign bus.busy       = busy;
  assign bus.cycle_done = done_r;

endmodule

// File: tb/tb_triwave_seq_ctrl.sv
// Bench for triwave_seq_ctrl. A period-level reference model expands each
// grant into a list of per-period duty values and checks every output on
// every clock; directed phases cover the documented scenarios, then random
// switch/step/hold settings with enable toggles and resets.
module tb_triwave_seq_ctrl;
  import triwave_seq_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 6;
  localparam int HOLD_W = 4;
  localparam int MAXV   = (1 << CNT_W) - 1;
  localparam int PERIOD = 1 << CNT_W;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  int   n_vec  = 0;
  int   n_err  = 0;

  triwave_seq_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .HOLD_W(HOLD_W)) bus ();

  triwave_seq_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .HOLD_W(HOLD_W)) dut (
    .sysclk (sysclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  // Reference model state
  int                m_count, m_duty, m_ch, m_ptr, m_idx;
  bit                m_busy, m_done;
  logic [NUM_CH-1:0] m_pulse;
  int                plan[$];

  // Observations of the DUT for directed checks
  int done_cnt;
  bit last_busy;
  int grants[$];
  int p2_high;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff(input int d);
`ifdef TRIWAVE_SEQ_GAMMA_EN
    return (d * d) >> CNT_W;
`else
    return d;
`endif
  endfunction

  // Duty seen during each PWM period of one grant, starting at the grant.
  function automatic void build_plan(input int s_in, input int h);
    int s;
    int d;
    s = (s_in == 0) ? 1 : s_in;
    d = 0;
    plan.delete();
    plan.push_back(0);
    while (d + s < MAXV) begin
      d += s;
      plan.push_back(d);
    end
    d = MAXV;
    repeat (h + 2) plan.push_back(MAXV);
    while (d > s) begin
      d -= s;
      plan.push_back(d);
    end
    repeat (h + 1) plan.push_back(0);
  endfunction

  function automatic void arbitrate();
    bit found;
    int c;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      c = (m_ptr + i) % NUM_CH;
      if (!found && bus.enable_sw[c]) begin
        found = 1'b1;
        m_ch  = c;
        m_ptr = c;
      end
    end
    m_duty = 0;
    m_idx  = 0;
    m_busy = found;
    if (found) build_plan(int'(bus.step), int'(bus.hold_periods));
  endfunction

  function automatic void model_step();
    if (!rst_n) begin
      m_count = 0;
      m_duty  = 0;
      m_ch    = 0;
      m_ptr   = NUM_CH - 1;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_pulse = '0;
      plan.delete();
    end else begin
      m_pulse = '0;
      if (m_busy && bus.enable_sw[m_ch] && (m_count < eff(m_duty))) m_pulse[m_ch] = 1'b1;
      m_done = 1'b0;
      if (m_count == MAXV) begin
        if (m_busy && !bus.enable_sw[m_ch]) begin
          m_busy = 1'b0;
          m_duty = 0;
        end else if (m_busy) begin
          m_idx++;
          if (m_idx < plan.size()) m_duty = plan[m_idx];
          else begin
            m_done = 1'b1;
            arbitrate();
          end
        end else begin
          arbitrate();
        end
      end
      m_count = (m_count + 1) % PERIOD;
    end
  endfunction

  task automatic tick();
    @(posedge sysclk);
    model_step();
    #1;
    check("pulse", bus.pulse, m_pulse);
    check("duty_cycle", bus.duty_cycle, eff(m_duty));
    check("active_ch", bus.active_ch, m_ch);
    check("busy", bus.busy, m_busy);
    check("cycle_done", bus.cycle_done, m_done);
    if (bus.cycle_done) done_cnt++;
    if (bus.busy && (!last_busy || bus.cycle_done)) grants.push_back(int'(bus.active_ch));
    if (bus.pulse[2]) p2_high++;
    last_busy = bus.busy;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    bit ok;
    start = done_cnt;
    ok    = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = (done_cnt != start);
    end
    check(tag, ok, 1'b1);
  endtask

  task automatic wait_duty(input string tag, input int d, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = bus.busy && (int'(bus.duty_cycle) == eff(d));
    end
    check(tag, ok, 1'b1);
  endtask

  int exp_order[4] = '{0, 1, 3, 0};

  initial begin
    bus.enable_sw    = '0;
    bus.step         = '0;
    bus.hold_periods = '0;
    last_busy        = 1'b0;
    done_cnt         = 0;
    p2_high          = 0;

    // Single channel, step 2, hold 1: full cycle then re-grant of ch0.
    bus.enable_sw    = 4'b0001;
    bus.step         = CNT_W'(2);
    bus.hold_periods = HOLD_W'(1);
    do_reset(3);
    wait_done("p1_cycle", 80 * PERIOD);
    repeat (3 * PERIOD) tick();
    check("p1_regrant_ch0", bus.active_ch, 0);

    // Round-robin over 1011: ch0, ch1, ch3, ch0; ch2 never pulses.
    bus.enable_sw    = 4'b1011;
    bus.step         = CNT_W'(16);
    bus.hold_periods = HOLD_W'(0);
    do_reset(2);
    grants.delete();
    done_cnt = 0;
    p2_high  = 0;
    repeat (3) wait_done("p2_cycle", 30 * PERIOD);
    check("p2_grant_count", grants.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < grants.size()) check($sformatf("p2_grant%0d", i), grants[i], exp_order[i]);
    check("p2_pulse2_high", p2_high, 0);

    // step 0 acts as 1; step 63 latched only at the following grant.
    bus.enable_sw    = 4'b0001;
    bus.step         = CNT_W'(0);
    bus.hold_periods = HOLD_W'(0);
    do_reset(2);
    repeat (4 * PERIOD) tick();
    bus.step = CNT_W'(63);
    wait_done("p3_step0_cycle", 140 * PERIOD);
    repeat (10 * PERIOD) tick();

    // Drop the active enable at duty 20, then re-enable with ch1 also set.
    bus.enable_sw    = 4'b0001;
    bus.step         = CNT_W'(4);
    bus.hold_periods = HOLD_W'(2);
    do_reset(2);
    wait_duty("p4_reach_20", 20, 10 * PERIOD);
    repeat (10) tick();
    bus.enable_sw = 4'b0000;
    repeat (2 * PERIOD) tick();
    check("p4_idle_after_drop", bus.busy, 1'b0);
    grants.delete();
    bus.enable_sw = 4'b0011;
    repeat (2) wait_done("p4_cycle", 50 * PERIOD);
    check("p4_first_regrant", (grants.size() > 0) ? grants[0] : -1, 1);
    check("p4_second_regrant", (grants.size() > 1) ? grants[1] : -1, 0);

    // One-clock reset while holding at the top of the ramp.
    bus.enable_sw    = 4'b0001;
    bus.step         = CNT_W'(8);
    bus.hold_periods = HOLD_W'(3);
    do_reset(2);
    wait_duty("p5_reach_max", MAXV, 12 * PERIOD);
    repeat (PERIOD + 10) tick();
    do_reset(1);
    check("p5_rst_busy", bus.busy, 1'b0);
    check("p5_rst_duty", bus.duty_cycle, 0);
    repeat (PERIOD + 2) tick();
    check("p5_regrant_busy", bus.busy, 1'b1);
    check("p5_regrant_ch0", bus.active_ch, 0);

    // Random switch/step/hold settings with occasional toggles and resets.
    for (int seg = 0; seg < 12; seg++) begin
      bus.enable_sw    = NUM_CH'($urandom);
      bus.step         = CNT_W'($urandom_range(0, MAXV));
      bus.hold_periods = HOLD_W'($urandom_range(0, (1 << HOLD_W) - 1));
      if ($urandom_range(0, 3) == 0) do_reset(1);
      for (int k = 0; k < 1500; k++) begin
        tick();
        if ($urandom_range(0, 499) == 0)
          bus.enable_sw = bus.enable_sw ^ (NUM_CH'(1) << $urandom_range(0, NUM_CH - 1));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
